aes_enc_scheduler: RTL and testbench

//   Shares one fully pipelined AES-128 encryption core between NUM_REQ requesters.

---
 rtl/aes_sched_pkg.sv | 22 ++
 rtl/aes_sched_rr_arb.sv | 31 +++
 rtl/aes_enc_scheduler.sv | 124 ++++++++++++
 tb/tb_aes_enc_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and helpers for the AES encryption-core scheduler.
package aes_sched_pkg;

    localparam int BLOCK_W  = 128;
    localparam int TAG_ID_W = 8;

    typedef logic [0:BLOCK_W-1] block_t;

    // One entry per core pipeline stage; the core itself carries no valid.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/aes_sched_rr_arb.sv
// Round-robin arbiter: first eligible requester at or after rr_ptr, with wrap.
module aes_sched_rr_arb
    import aes_sched_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner_id
);

    always_comb begin
        logic found;
        int   idx;
        grant     = '0;
        winner_id = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner_id  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/aes_enc_scheduler.sv
// Shares one pipelined AES-128 core between NUM_REQ requesters; tracks blocks in
// flight with a tag pipe and absorbs results in a credit-checked output FIFO.
module aes_enc_scheduler
    import aes_sched_pkg::*;
#(
    parameter  int NUM_REQ   = 2,
    parameter  int CORE_LAT  = 11,
    parameter  int OUT_DEPTH = 16,
    localparam int ID_W      = clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*BLOCK_W-1:0] req_pt,
    input  logic [NUM_REQ*BLOCK_W-1:0] req_key,
    output logic [BLOCK_W-1:0]         core_pt,
    output logic [BLOCK_W-1:0]         core_key,
    input  logic [BLOCK_W-1:0]         core_ct,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BLOCK_W-1:0]         out_ct,
    output logic [ID_W-1:0]            out_id,
    output logic                       busy
);

    localparam int CNT_W = clog2(OUT_DEPTH + 1);
    localparam int PTR_W = clog2(OUT_DEPTH);

    // Handshakes: a transfer happens in a cycle where valid and ready are both 1;
    // valid may drop before its handshake, ready never waits on anything but credit.
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    winner_id;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [CNT_W:0]     occupied;
    logic               has_credit;
    logic               hs;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   inflight;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    tag_t               tag_q   [CORE_LAT];
    block_t             fifo_ct [OUT_DEPTH];
    logic [ID_W-1:0]    fifo_id [OUT_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit uses registered counts only, so a same-cycle pop never frees a slot.
    assign occupied   = {1'b0, fifo_count} + {1'b0, inflight};
    assign has_credit = occupied < (CNT_W + 1)'(OUT_DEPTH);
    assign eligible   = req_valid & {NUM_REQ{has_credit}};

    aes_sched_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .winner_id (winner_id)
    );

    assign req_ready = rst ? grant : '0;
    assign hs        = |grant;
    assign push      = tag_q[CORE_LAT-1].valid;
    assign out_valid = fifo_count != '0;
    assign pop       = out_valid & out_ready;
    assign fifo_full = fifo_count == CNT_W'(OUT_DEPTH);
    assign out_ct    = fifo_ct[rd_ptr];
    assign out_id    = fifo_id[rd_ptr];
    assign busy      = (inflight != '0) || (fifo_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr     <= '0;
            core_pt    <= '0;
            core_key   <= '0;
            fifo_count <= '0;
            inflight   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            for (int k = 0; k < CORE_LAT; k++) tag_q[k] <= '0;
        end else begin
            if (hs) begin
                rr_ptr   <= (winner_id == ID_W'(NUM_REQ - 1)) ? '0 : winner_id + 1'b1;
                core_pt  <= req_pt[int'(winner_id)*BLOCK_W +: BLOCK_W];
                core_key <= req_key[int'(winner_id)*BLOCK_W +: BLOCK_W];
            end
            tag_q[0] <= hs ? {1'b1, TAG_ID_W'(winner_id)} : '0;
            for (int k = 1; k < CORE_LAT; k++) tag_q[k] <= tag_q[k-1];
            case ({hs, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_ct[wr_ptr] <= core_ct;
            fifo_id[wr_ptr] <= tag_q[CORE_LAT-1].id[ID_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(push && fifo_full && !pop));
            assert ($onehot0(req_ready));
            assert ((tag_q[CORE_LAT-1].id >> ID_W) == '0);
        end
    end

endmodule

// File: tb/tb_aes_enc_scheduler.sv
// Bench for aes_enc_scheduler with a behavioural AES core and a queue-based model.
module tb_aes_enc_scheduler;

    localparam int NUM_REQ   = 2;
    localparam int CORE_LAT  = 11;
    localparam int OUT_DEPTH = 16;
    localparam int ID_W      = 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [255:0]       req_pt;
    logic [255:0]       req_key;
    logic [127:0]       core_pt;
    logic [127:0]       core_key;
    logic [127:0]       core_ct;
    logic               out_valid;
    logic               out_ready;
    logic [127:0]       out_ct;
    logic [ID_W-1:0]    out_id;
    logic               busy;

    logic [127:0] pt_lane  [2];
    logic [127:0] key_lane [2];
    logic [127:0] pipe     [CORE_LAT-1];
    logic [7:0]   sbox_t   [256];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int model_rr = 0;
    int hs_cnt, pop_cnt, first_hs_cyc, last_hs_cyc, last_pop_cyc, first_valid_cyc;
    logic [127:0] first_ct;
    int t_issue;

    logic [127:0] exp_q   [$];
    int           exp_id_q[$];
    logic [127:0] fl_q    [$];
    int           fl_id_q [$];
    int           fl_due_q[$];

    always #5 clk = ~clk;

    assign req_pt  = {pt_lane[1], pt_lane[0]};
    assign req_key = {key_lane[1], key_lane[0]};

    aes_enc_scheduler #(.NUM_REQ(NUM_REQ), .CORE_LAT(CORE_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pt    (req_pt),
        .req_key   (req_key),
        .core_pt   (core_pt),
        .core_key  (core_key),
        .core_ct   (core_ct),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ct    (out_ct),
        .out_id    (out_id),
        .busy      (busy)
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s[16];
        logic [7:0] k[16];
        logic [7:0] t[16];
        logic [7:0] rc, a0, a1, a2, a3, w0, w1, w2, w3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            w0 = sbox_t[k[13]] ^ rc;
            w1 = sbox_t[k[14]];
            w2 = sbox_t[k[15]];
            w3 = sbox_t[k[12]];
            k[0] = k[0] ^ w0;
            k[1] = k[1] ^ w1;
            k[2] = k[2] ^ w2;
            k[3] = k[3] ^ w3;
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    s[row+4*col] = t[row+4*((col+row)%4)];
            if (r < 10) begin
                for (int col = 0; col < 4; col++) begin
                    a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
                    s[4*col]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*col+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*col+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*col+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    initial begin
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl1(inv) ^ rotl1(rotl1(inv)) ^ rotl1(rotl1(rotl1(inv)))
                        ^ rotl1(rotl1(rotl1(rotl1(inv)))) ^ 8'h63;
        end
        for (int k = 0; k < CORE_LAT - 1; k++) pipe[k] = '0;
    end

    // Stand-in for the external core: ciphertext appears CORE_LAT cycles after load.
    always @(posedge clk) begin
        for (int k = CORE_LAT - 2; k > 0; k--) pipe[k] <= pipe[k-1];
        pipe[0] <= aes_enc(core_pt, core_key);
    end
    assign core_ct = pipe[CORE_LAT-2];

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete(); exp_id_q.delete();
        fl_q.delete(); fl_id_q.delete(); fl_due_q.delete();
        model_rr = 0;
    endtask

    // One clock cycle: drive, check against the model mid-cycle, advance past the edge.
    task automatic run_cycle(input logic [1:0] v, input logic ordy, input logic rnd);
        int credit;
        int win;
        int idx;
        logic [1:0] exp_ready;
        req_valid = v;
        out_ready = ordy;
        if (rnd) begin
            for (int i = 0; i < 2; i++) begin
                pt_lane[i]  = {$urandom, $urandom, $urandom, $urandom};
                key_lane[i] = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        #2;
        while (fl_due_q.size() > 0 && fl_due_q[0] == cyc) begin
            exp_q.push_back(fl_q.pop_front());
            exp_id_q.push_back(fl_id_q.pop_front());
            void'(fl_due_q.pop_front());
        end
        credit = OUT_DEPTH - exp_q.size() - fl_q.size();
        win = -1;
        if (credit > 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (model_rr + k) % NUM_REQ;
                if (win < 0 && v[idx]) win = idx;
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        check("req_ready", 128'(req_ready), 128'(exp_ready));
        check("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
        check("busy", 128'(busy), 128'(exp_q.size() > 0 || fl_q.size() > 0));
        if (exp_q.size() > 0) begin
            check("out_ct", out_ct, exp_q[0]);
            check("out_id", 128'(out_id), 128'(exp_id_q[0]));
        end
        if (out_valid && first_valid_cyc < 0) begin
            first_valid_cyc = cyc;
            first_ct = out_ct;
        end
        if (out_valid && out_ready) begin
            pop_cnt++;
            last_pop_cyc = cyc;
        end
        if (|(req_valid & req_ready)) begin
            if (hs_cnt == 0) first_hs_cyc = cyc;
            hs_cnt++;
            last_hs_cyc = cyc;
        end
        if (win >= 0) begin
            fl_q.push_back(aes_enc(pt_lane[win], key_lane[win]));
            fl_id_q.push_back(win);
            fl_due_q.push_back(cyc + CORE_LAT + 1);
            model_rr = (win + 1) % NUM_REQ;
        end
        if (exp_q.size() > 0 && ordy) begin
            void'(exp_q.pop_front());
            void'(exp_id_q.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 128'(req_ready), 128'(0));
        check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_core_pt"}, core_pt, 128'(0));
        check({tag, "_core_key"}, core_key, 128'(0));
    endtask

    initial begin
        req_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pt_lane[i]  = '0;
            key_lane[i] = '0;
        end
        hs_cnt = 0; pop_cnt = 0; first_hs_cyc = -1; last_hs_cyc = -1;
        last_pop_cyc = -1; first_valid_cyc = -1; first_ct = '0;

        // Reset state, with requests pending so req_ready gating is visible.
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b11;
        #1;
        check_reset_outputs("reset");
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();

        // Known-answer block from requester 0 and its exact latency.
        pt_lane[0]  = 128'h00112233445566778899aabbccddeeff;
        key_lane[0] = 128'h000102030405060708090a0b0c0d0e0f;
        t_issue = cyc;
        first_valid_cyc = -1;
        run_cycle(2'b01, 1'b1, 1'b0);
        repeat (15) run_cycle(2'b00, 1'b1, 1'b0);
        check("kat_latency", 128'(first_valid_cyc), 128'(t_issue + CORE_LAT + 1));
        check("kat_ct", first_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // Both requesters streaming with the output always ready.
        hs_cnt = 0;
        repeat (30) run_cycle(2'b11, 1'b1, 1'b1);
        check("stream_hs_count", 128'(hs_cnt), 128'(30));
        repeat (15) run_cycle(2'b00, 1'b1, 1'b0);

        // Back-pressure: credit stops admission at OUT_DEPTH blocks.
        hs_cnt = 0;
        pop_cnt = 0;
        repeat (30) run_cycle(2'b11, 1'b0, 1'b1);
        check("bp_hs_count", 128'(hs_cnt), 128'(OUT_DEPTH));
        // Full FIFO popped while new blocks arrive: simultaneous push and pop near full.
        repeat (20) run_cycle(2'b11, 1'b1, 1'b1);
        repeat (30) run_cycle(2'b00, 1'b1, 1'b0);
        check("bp_drain_count", 128'(pop_cnt), 128'(hs_cnt));
        check("bp_min_pops", 128'(pop_cnt >= OUT_DEPTH), 128'(1));

        // Reset with 3 results queued and 5 blocks in the core.
        repeat (3) run_cycle(2'b01, 1'b0, 1'b1);
        repeat (6) run_cycle(2'b00, 1'b0, 1'b0);
        repeat (5) run_cycle(2'b01, 1'b0, 1'b1);
        run_cycle(2'b00, 1'b0, 1'b0);
        check("pre_reset_valid", 128'(out_valid), 128'(1));
        rst = 1'b0;
        req_valid = 2'b11;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = '0;
        cyc++;
        model_clear();
        first_valid_cyc = -1;
        repeat (20) run_cycle(2'b00, 1'b1, 1'b0);
        check("post_reset_quiet", 128'(first_valid_cyc), 128'(-1));

        // One requester, 100 back-to-back blocks.
        hs_cnt = 0;
        repeat (100) run_cycle(2'b01, 1'b1, 1'b1);
        check("solo_hs_count", 128'(hs_cnt), 128'(100));
        check("solo_hs_span", 128'(last_hs_cyc - first_hs_cyc), 128'(99));
        repeat (20) run_cycle(2'b00, 1'b1, 1'b0);
        check("solo_last_latency", 128'(last_pop_cyc), 128'(last_hs_cyc + CORE_LAT + 1));
        check("solo_idle", 128'(busy), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
